fir_mux_seq: RTL and testbench

- Parametrised, registered N:1 channel multiplexer with a built-in scan sequencer for the time-multiplexed FIR datapath.
- Selects one of NUM_CH tap/sample words of WIDTH bits, either on demand (manual mode) or as an automatic 0..NUM_CH-1 burst (scan mode).
- Presents the selected word through a one-entry output register with a valid/ready handshake, so it can feed a shared multiplier-accumulator that may stall.

---
 rtl/fir_mux_seq.sv | 139 +++++++++++++
 tb/tb_fir_mux_seq.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mux_seq.sv
// Registered N:1 channel multiplexer with a scan sequencer for the time-multiplexed FIR datapath.
// Manual mode selects one channel per request. Scan mode bursts channels 0..NUM_CH-1 through a one-entry valid/ready register.
module fir_mux_seq #(
    parameter  int WIDTH  = 8,
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic [NUM_CH*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    sel_valid,
    input  logic                    start,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        dout,
    output logic [SEL_W-1:0]        dout_ch,
    output logic                    dout_valid,
    output logic                    dout_last,
    output logic                    busy,
    output logic                    sel_err
);

    typedef enum logic {IDLE, SCAN} state_e;

    localparam logic [SEL_W:0]   NUM_CH_W = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q;
    logic [SEL_W-1:0] doutCh_q;
    logic             doutValid_q, doutLast_q;
    logic             selErr_q, selErr_d;

    logic             load;
    logic             capture;
    logic             capLast;
    logic [SEL_W-1:0] capCh;
    logic             selInRange;
    logic [WIDTH-1:0] chan [NUM_CH];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign chan[k] = din[k*WIDTH +: WIDTH];
    end

    assign load       = !doutValid_q || out_ready;
    assign selInRange = ({1'b0, sel} < NUM_CH_W);

    // State, scan counter and the one-entry output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dout_q      <= '0;
            doutCh_q    <= '0;
            doutValid_q <= 1'b0;
            doutLast_q  <= 1'b0;
            selErr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            selErr_q <= selErr_d;
            if (load) begin
                doutValid_q <= capture;
                if (capture) begin
                    dout_q     <= chan[capCh];
                    doutCh_q   <= capCh;
                    doutLast_q <= capLast;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mode && start && load) begin
                    state_d = SCAN;
                    cnt_d   = SEL_W'(1);
                end
            end
            SCAN: begin
                if (load) begin
                    if (cnt_q == LAST_CH) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan start always captures channel 0; a rejected manual request only raises the error pulse.
    always_comb begin
        capture  = 1'b0;
        capCh    = '0;
        capLast  = 1'b0;
        selErr_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!mode) begin
                    if (sel_valid && load) begin
                        if (selInRange) begin
                            capture = 1'b1;
                            capCh   = sel;
                            capLast = 1'b1;
                        end else begin
                            selErr_d = 1'b1;
                        end
                    end
                end else if (start && load) begin
                    capture = 1'b1;
                end
            end
            SCAN: begin
                if (load) begin
                    capture = 1'b1;
                    capCh   = cnt_q;
                    capLast = (cnt_q == LAST_CH);
                end
            end
            default: capture = 1'b0;
        endcase
    end

    assign dout       = dout_q;
    assign dout_ch    = doutCh_q;
    assign dout_valid = doutValid_q;
    assign dout_last  = doutLast_q;
    assign busy       = (state_q == SCAN);
    assign sel_err    = selErr_q;

endmodule

// File: tb/tb_fir_mux_seq.sv
// Scoreboard bench for fir_mux_seq: manual select, scan bursts, backpressure, ignore cases, reset and sel_err.
// Inputs are driven and outputs sampled on the falling edge.
module tb_fir_mux_seq;

    localparam int WIDTH  = 8;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] ch;
        logic             last;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    mode, sel_valid, start, out_ready;
    logic [NUM_CH*WIDTH-1:0] din;
    logic [SEL_W-1:0]        sel;
    logic [WIDTH-1:0]        dout;
    logic [SEL_W-1:0]        dout_ch;
    logic                    dout_valid, dout_last, busy, sel_err;

    logic                    mode3, sel_valid3, start3, out_ready3;
    logic [3*WIDTH-1:0]      din3;
    logic [1:0]              sel3;
    logic [WIDTH-1:0]        dout3;
    logic [1:0]              dout_ch3;
    logic                    dout_valid3, dout_last3, busy3, sel_err3;

    exp_t             sbq[$];
    int               vectors     = 0;
    int               miscompares = 0;
    logic [WIDTH-1:0] chVal [NUM_CH] = '{8'h11, 8'h22, 8'h33, 8'h44};

    always #5 clk = ~clk;

    fir_mux_seq #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .din(din), .sel(sel),
        .sel_valid(sel_valid), .start(start), .out_ready(out_ready),
        .dout(dout), .dout_ch(dout_ch), .dout_valid(dout_valid),
        .dout_last(dout_last), .busy(busy), .sel_err(sel_err)
    );

    fir_mux_seq #(.WIDTH(WIDTH), .NUM_CH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .din(din3), .sel(sel3),
        .sel_valid(sel_valid3), .start(start3), .out_ready(out_ready3),
        .dout(dout3), .dout_ch(dout_ch3), .dout_valid(dout_valid3),
        .dout_last(dout_last3), .busy(busy3), .sel_err(sel_err3)
    );

    task automatic pushScan;
        exp_t e;
        for (int k = 0; k < NUM_CH; k++) begin
            e.data = chVal[k];
            e.ch   = SEL_W'(k);
            e.last = (k == NUM_CH - 1);
            sbq.push_back(e);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        vectors++;
        if ({dout, dout_ch, dout_valid, dout_last, busy, sel_err} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got dout=%h ch=%0d v=%b l=%b busy=%b err=%b, want all 0",
                     dout, dout_ch, dout_valid, dout_last, busy, sel_err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_manual;
        exp_t e;
        mode = 1'b0;
        out_ready = 1'b1;
        for (int i = 2; i < NUM_CH; i++) begin
            @(negedge clk);
            sel = SEL_W'(i);
            sel_valid = 1'b1;
            start = 1'b1;
            e.data = chVal[i];
            e.ch   = SEL_W'(i);
            e.last = 1'b1;
            sbq.push_back(e);
            @(negedge clk);
            sel_valid = 1'b0;
            start = 1'b0;
            vectors++;
            if (dout_valid !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL manual_valid: got %b, want 1", dout_valid);
            end
            if (dout_valid && out_ready && sbq.size() > 0) begin
                e = sbq.pop_front();
                vectors++;
                if ({dout, dout_ch, dout_last} !== {e.data, e.ch, e.last}) begin
                    miscompares++;
                    $display("[TB] FAIL manual_word: got %h/ch%0d/last%b, want %h/ch%0d/last%b",
                             dout, dout_ch, dout_last, e.data, e.ch, e.last);
                end
            end
            @(negedge clk);
            vectors++;
            if (dout_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL manual_pulse: got valid=%b busy=%b, want 0/0", dout_valid, busy);
            end
        end
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL manual_queue: got %0d pending, want 0", sbq.size());
        end
        sbq.delete();
    endtask

    task automatic test_scan;
        exp_t e;
        int   busyCycles = 0;
        mode = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        pushScan();
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busyCycles++;
            if (c <= NUM_CH) begin
                vectors++;
                if (dout_valid !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL scan_gap: cycle %0d valid=%b, want 1", c, dout_valid);
                end
            end
            if (dout_valid && out_ready && sbq.size() > 0) begin
                e = sbq.pop_front();
                vectors++;
                if ({dout, dout_ch, dout_last} !== {e.data, e.ch, e.last}) begin
                    miscompares++;
                    $display("[TB] FAIL scan_word: got %h/ch%0d/last%b, want %h/ch%0d/last%b",
                             dout, dout_ch, dout_last, e.data, e.ch, e.last);
                end
            end
        end
        vectors++;
        if (busyCycles != 3) begin
            miscompares++;
            $display("[TB] FAIL scan_busy: got %0d busy cycles, want 3", busyCycles);
        end
        vectors++;
        if (sbq.size() != 0 || dout_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL scan_end: got %0d pending valid=%b, want 0/0", sbq.size(), dout_valid);
        end
        sbq.delete();
    endtask

    task automatic test_backpressure;
        exp_t e;
        mode = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        pushScan();
        for (int c = 1; c <= 12 && sbq.size() > 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            out_ready = !(c >= 2 && c <= 4);
            if (!out_ready) begin
                vectors++;
                if ({dout, dout_ch, dout_valid} !== {8'h22, 2'd1, 1'b1}) begin
                    miscompares++;
                    $display("[TB] FAIL bp_hold: got %h/ch%0d/v%b, want 22/ch1/v1", dout, dout_ch, dout_valid);
                end
            end
            if (dout_valid && out_ready) begin
                e = sbq.pop_front();
                vectors++;
                if ({dout, dout_ch, dout_last} !== {e.data, e.ch, e.last}) begin
                    miscompares++;
                    $display("[TB] FAIL bp_word: got %h/ch%0d/last%b, want %h/ch%0d/last%b",
                             dout, dout_ch, dout_last, e.data, e.ch, e.last);
                end
            end
        end
        out_ready = 1'b1;
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL bp_queue: got %0d pending, want 0", sbq.size());
        end
        sbq.delete();
        @(negedge clk);
    endtask

    task automatic test_ignore;
        exp_t e;
        mode = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        pushScan();
        for (int c = 1; c <= 8 && sbq.size() > 0; c++) begin
            @(negedge clk);
            if (c <= 2) begin
                sel = 2'd3;
                sel_valid = 1'b1;
                start = 1'b1;
                mode = 1'b0;
            end else begin
                sel_valid = 1'b0;
                start = 1'b0;
                mode = 1'b1;
            end
            if (dout_valid && out_ready) begin
                e = sbq.pop_front();
                vectors++;
                if ({dout, dout_ch, dout_last} !== {e.data, e.ch, e.last}) begin
                    miscompares++;
                    $display("[TB] FAIL ignore_word: got %h/ch%0d/last%b, want %h/ch%0d/last%b",
                             dout, dout_ch, dout_last, e.data, e.ch, e.last);
                end
            end
        end
        @(negedge clk);
        vectors++;
        if (sbq.size() != 0 || dout_valid !== 1'b0 || busy !== 1'b0 || sel_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ignore_end: got pending=%0d valid=%b busy=%b err=%b, want 0/0/0/0",
                     sbq.size(), dout_valid, busy, sel_err);
        end
        sbq.delete();
    endtask

    task automatic test_back_to_back;
        exp_t e;
        mode = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        pushScan();
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = (c == NUM_CH);
            if (c == NUM_CH) pushScan();
            if (c <= 2*NUM_CH) begin
                vectors++;
                if (dout_valid !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_bubble: cycle %0d valid=%b, want 1", c, dout_valid);
                end
            end
            if (dout_valid && out_ready && sbq.size() > 0) begin
                e = sbq.pop_front();
                vectors++;
                if ({dout, dout_ch, dout_last} !== {e.data, e.ch, e.last}) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_word: got %h/ch%0d/last%b, want %h/ch%0d/last%b",
                             dout, dout_ch, dout_last, e.data, e.ch, e.last);
                end
            end
        end
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL b2b_queue: got %0d pending, want 0", sbq.size());
        end
        sbq.delete();
    endtask

    task automatic test_reset_midscan;
        exp_t e;
        mode = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        pushScan();
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            start = 1'b0;
            e = sbq.pop_front();
            vectors++;
            if ({dout_valid, dout, dout_ch, dout_last} !== {1'b1, e.data, e.ch, e.last}) begin
                miscompares++;
                $display("[TB] FAIL rst_pre: got v%b %h/ch%0d/last%b, want v1 %h/ch%0d/last%b",
                         dout_valid, dout, dout_ch, dout_last, e.data, e.ch, e.last);
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({dout, dout_ch, dout_valid, dout_last, busy, sel_err} !== '0) begin
            miscompares++;
            $display("[TB] FAIL rst_mid: got dout=%h ch=%0d v=%b l=%b busy=%b err=%b, want all 0",
                     dout, dout_ch, dout_valid, dout_last, busy, sel_err);
        end
        sbq.delete();
        start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        pushScan();
        for (int c = 1; c <= 6 && sbq.size() > 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (dout_valid && out_ready) begin
                e = sbq.pop_front();
                vectors++;
                if ({dout, dout_ch, dout_last} !== {e.data, e.ch, e.last}) begin
                    miscompares++;
                    $display("[TB] FAIL rst_restart: got %h/ch%0d/last%b, want %h/ch%0d/last%b",
                             dout, dout_ch, dout_last, e.data, e.ch, e.last);
                end
            end
        end
        start = 1'b0;
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL rst_queue: got %0d pending, want 0", sbq.size());
        end
        sbq.delete();
        @(negedge clk);
    endtask

    task automatic test_sel_err;
        @(negedge clk);
        sel3 = 2'd3;
        sel_valid3 = 1'b1;
        @(negedge clk);
        sel_valid3 = 1'b0;
        vectors++;
        if (sel_err3 !== 1'b1 || dout_valid3 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL selerr_pulse: got err=%b valid=%b, want 1/0", sel_err3, dout_valid3);
        end
        @(negedge clk);
        vectors++;
        if (sel_err3 !== 1'b0 || dout_valid3 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL selerr_clear: got err=%b valid=%b, want 0/0", sel_err3, dout_valid3);
        end
        sel3 = 2'd2;
        sel_valid3 = 1'b1;
        @(negedge clk);
        sel_valid3 = 1'b0;
        vectors++;
        if ({dout_valid3, dout3, dout_ch3, dout_last3, sel_err3} !== {1'b1, 8'h33, 2'd2, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL selerr_lastch: got v%b %h/ch%0d/last%b err=%b, want v1 33/ch2/last1 err0",
                     dout_valid3, dout3, dout_ch3, dout_last3, sel_err3);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        mode = 1'b0;
        sel = '0;
        sel_valid = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        din = {8'h44, 8'h33, 8'h22, 8'h11};
        mode3 = 1'b0;
        sel3 = '0;
        sel_valid3 = 1'b0;
        start3 = 1'b0;
        out_ready3 = 1'b1;
        din3 = {8'h33, 8'h22, 8'h11};

        test_reset();
        test_manual();
        test_scan();
        test_backpressure();
        test_ignore();
        test_back_to_back();
        test_reset_midscan();
        test_sel_err();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
